glyph_fetch_pipe: RTL
=====================

Name: glyph_fetch_pipe

Overview:
Pixel-rate text-glyph fetch stage that sits directly upstream of bit_combiner. It consumes raw video timing and pattern data from the pixel engine and tracks raster position. It issues font_rom reads for a 16x32 glyph box and re-times the video so each ROM bit, its overlay_enable and its base pixel leave aligned on one cycle. Glyph box position and glyph offset change only at frame boundaries, so the glyph never tears mid-frame.

Parameters:
H_ACTIVE, 1920, active pixels per line
V_ACTIVE, 1080, active lines per frame
GLYPH_W, 16, glyph width in pixels
GLYPH_H, 32, glyph height in lines
ROM_LAT, 1, font_rom read latency in clocks (1..3)
X_INIT, 300, box x position after reset
Y_INIT, 500, box y position after reset
STEP_X, 10, x increment per move
STEP_Y, 18, y increment per move

Ports:
vpg_pclk  in  1  pixel clock, sole clock
reset  in  1  synchronous, active-high reset
vpg_de  in  1  data enable
vpg_hs  in  1  hsync, active low
vpg_vs  in  1  vsync, active low
vpg_d  in  24  base pixel {R,G,B}
glyph_offset  in  11  font_rom base address of selected glyph
move_req  in  1  level; advance box position at next frame start
rom_address  out  11  font_rom address
rom_rden  out  1  read enable, high only inside box
rom_q  in  1  font_rom data, valid ROM_LAT clocks after address
out_de/out_hs/out_vs  out  1 each  delayed timing
out_d  out  24  delayed base pixel, to bit_combiner PPE_IN
ovl_bit  out  1  glyph bit, to bit repeater
ovl_en  out  1  overlay_enable, to bit_combiner

Behaviour:
- Counters: x_cnt (12b) is 0 on the first DE-high pixel and +1 per DE-high clock. It clears while DE is low. y_cnt (12b) increments on each DE falling edge and clears while vpg_vs is low.
- Frame start (FS) = vpg_vs 1->0 edge, detected using registered previous VS. At FS:
  - glyph_offset latches into off_q.
  - armed is set.
  - If move_req=1: x_pos += STEP_X, or wraps to 0 when the result > H_ACTIVE-GLYPH_W. y_pos += STEP_Y, or wraps to 0 when the result > V_ACTIVE-GLYPH_H.
- in_box = DE & armed & x_pos<=x_cnt<x_pos+GLYPH_W & y_pos<=y_cnt<y_pos+GLYPH_H.
- Stage A (registered, input cycle N -> N+1):
  - rom_address = off_q + (y_cnt-y_pos)*GLYPH_W + (x_cnt-x_pos), truncated to 11 bits. Wrap past 2047 is allowed.
  - Outside the box, rom_address = off_q.
  - rom_rden = in_box.
- A delay line of ROM_LAT+1 registers carries DE/HS/VS/D and in_box.
- Output stage registers rom_q gated by the delayed in_box into ovl_bit. ovl_en = delayed in_box.
- Total latency from vpg_* to out_* is ROM_LAT+2 clocks (3 at default). There is no back-pressure.
- Reset values:
  - out_de=0, out_hs=1, out_vs=1, out_d=0, ovl_bit=0, ovl_en=0.
  - rom_rden=0, rom_address=0, off_q=0.
  - x_pos=X_INIT, y_pos=Y_INIT, counters 0, armed=0, delay line cleared with HS/VS=1.
- Reset mid-frame: armed=0, so ovl_en and rom_rden stay 0 until the first FS after reset. Video pass-through resumes immediately with normal latency.
- Box partially beyond the active edge: only pixels with DE high are overlaid. There is no wrap onto the next line.
- glyph_offset or move_req changing mid-frame has no effect until the next FS.
- FS coinciding with DE high (malformed timing): the FS update still applies, and y_cnt clears.

Optional Feature:
GLYPH_SCALE2X_EN
- Defined: the box is 2*GLYPH_W x 2*GLYPH_H. ROM row and column use (y_cnt-y_pos)>>1 and (x_cnt-x_pos)>>1. Wrap limits use the doubled size.
- Undefined: 1:1 glyph as described above.

Test Plan:
1. Hold reset 4 clocks, toggling inputs -> all outputs at reset values. Release -> out_d tracks vpg_d 3 clocks later, ovl_en=0 until first FS.
2. H_ACTIVE=64, V_ACTIVE=48, X_INIT=8, Y_INIT=4, glyph_offset=512, rom_q=address[0] -> ovl_en high exactly for x 8..23, y 4..35. rom_address=512 at (8,4), 1023 at (23,35). ovl_bit matches address LSB with 3-clock alignment.
3. Same setup, move_req=1 across FS -> box at x=18, y=22 next frame. Repeat until x would exceed 48 -> x_pos=0.
4. glyph_offset changed 0->1536 mid-frame -> current frame addresses still use 0. Next frame starts at 1536.
5. Reset pulsed mid-line inside the box -> ovl_en drops at once, stays 0 through the remaining frame, reappears the frame after the next FS.
6. With GLYPH_SCALE2X_EN, params from test 2 -> ovl_en for x 8..39, y 4..67 clipped to active. rom_address stays constant across each 2x2 pixel group.

Source files
------------

// File: rtl/glyph_fetch_pipe_if.sv
// Video-in, font_rom and video-out signal bundle for glyph_fetch_pipe.
// slave = the fetch stage itself, master = pixel engine / ROM / downstream side.
interface glyph_fetch_pipe_if;
    logic        vpg_de;
    logic        vpg_hs;
    logic        vpg_vs;
    logic [23:0] vpg_d;
    logic [10:0] glyph_offset;
    logic        move_req;

    logic [10:0] rom_address;
    logic        rom_rden;
    logic        rom_q;

    logic        out_de;
    logic        out_hs;
    logic        out_vs;
    logic [23:0] out_d;
    logic        ovl_bit;
    logic        ovl_en;

    modport slave (
        input  vpg_de, vpg_hs, vpg_vs, vpg_d, glyph_offset, move_req, rom_q,
        output rom_address, rom_rden, out_de, out_hs, out_vs, out_d, ovl_bit, ovl_en
    );

    modport master (
        output vpg_de, vpg_hs, vpg_vs, vpg_d, glyph_offset, move_req, rom_q,
        input  rom_address, rom_rden, out_de, out_hs, out_vs, out_d, ovl_bit, ovl_en
    );
endinterface

// File: rtl/glyph_fetch_pipe.sv
// Raster-tracking glyph fetch: issues font_rom reads for the glyph box and re-times video.
// Define GLYPH_SCALE2X_EN to draw each glyph bit as a 2x2 pixel block.
module glyph_fetch_pipe #(
    parameter int unsigned H_ACTIVE = 1920,
    parameter int unsigned V_ACTIVE = 1080,
    parameter int unsigned GLYPH_W  = 16,
    parameter int unsigned GLYPH_H  = 32,
    parameter int unsigned ROM_LAT  = 1,
    parameter int unsigned X_INIT   = 300,
    parameter int unsigned Y_INIT   = 500,
    parameter int unsigned STEP_X   = 10,
    parameter int unsigned STEP_Y   = 18
) (
    input  logic              vpg_pclk,
    input  logic              reset,
    glyph_fetch_pipe_if.slave bus
);
    localparam int unsigned CNT_W  = 12;
    localparam int unsigned SUM_W  = 13;
    localparam int unsigned ADDR_W = 11;
    localparam int unsigned PIX_W  = 24;
    localparam int unsigned DLY_N  = ROM_LAT + 1;
`ifdef GLYPH_SCALE2X_EN
    localparam int unsigned BOX_W  = 2 * GLYPH_W;
    localparam int unsigned BOX_H  = 2 * GLYPH_H;
    localparam int unsigned SHIFT  = 1;
`else
    localparam int unsigned BOX_W  = GLYPH_W;
    localparam int unsigned BOX_H  = GLYPH_H;
    localparam int unsigned SHIFT  = 0;
`endif
    localparam int unsigned X_LIM  = H_ACTIVE - BOX_W;
    localparam int unsigned Y_LIM  = V_ACTIVE - BOX_H;

    typedef struct packed {
        logic             de;
        logic             hs;
        logic             vs;
        logic             in_box;
        logic [PIX_W-1:0] d;
    } vid_t;

    localparam vid_t VID_RST = '{de: 1'b0, hs: 1'b1, vs: 1'b1, in_box: 1'b0, d: '0};

    logic              r_vs_prev;
    logic              r_de_prev;
    logic              r_armed;
    logic [CNT_W-1:0]  r_x_cnt;
    logic [CNT_W-1:0]  r_y_cnt;
    logic [CNT_W-1:0]  r_x_pos;
    logic [CNT_W-1:0]  r_y_pos;
    logic [ADDR_W-1:0] r_off_q;
    logic [ADDR_W-1:0] r_rom_address;
    logic              r_rom_rden;
    vid_t              r_dly [DLY_N];
    logic              r_out_de;
    logic              r_out_hs;
    logic              r_out_vs;
    logic [PIX_W-1:0]  r_out_d;
    logic              r_ovl_bit;
    logic              r_ovl_en;

    logic              w_fs;
    logic              w_de_fall;
    logic              w_in_x;
    logic              w_in_y;
    logic              w_in_box;
    logic [SUM_W-1:0]  w_x_end;
    logic [SUM_W-1:0]  w_y_end;
    logic [SUM_W-1:0]  w_x_next;
    logic [SUM_W-1:0]  w_y_next;
    logic [CNT_W-1:0]  w_x_rel;
    logic [CNT_W-1:0]  w_y_rel;
    logic [CNT_W-1:0]  w_col;
    logic [CNT_W-1:0]  w_row;
    logic [ADDR_W-1:0] w_addr;
    vid_t              w_tail;

    // Box hit test, glyph-relative address and next box position.
    always_comb begin
        w_fs      = r_vs_prev & ~bus.vpg_vs;
        w_de_fall = r_de_prev & ~bus.vpg_de;
        w_x_end   = SUM_W'(r_x_pos) + SUM_W'(BOX_W);
        w_y_end   = SUM_W'(r_y_pos) + SUM_W'(BOX_H);
        w_in_x    = (r_x_cnt >= r_x_pos) && (SUM_W'(r_x_cnt) < w_x_end);
        w_in_y    = (r_y_cnt >= r_y_pos) && (SUM_W'(r_y_cnt) < w_y_end);
        w_in_box  = bus.vpg_de & r_armed & w_in_x & w_in_y;
        w_x_rel   = r_x_cnt - r_x_pos;
        w_y_rel   = r_y_cnt - r_y_pos;
        w_col     = w_x_rel >> SHIFT;
        w_row     = w_y_rel >> SHIFT;
        w_addr    = r_off_q + ADDR_W'(w_row * CNT_W'(GLYPH_W)) + ADDR_W'(w_col);
        w_x_next  = SUM_W'(r_x_pos) + SUM_W'(STEP_X);
        w_y_next  = SUM_W'(r_y_pos) + SUM_W'(STEP_Y);
        w_tail    = r_dly[DLY_N-1];
    end

    // Raster counters; x is the index of the current DE-high pixel.
    always_ff @(posedge vpg_pclk) begin
        if (reset) begin
            r_vs_prev <= 1'b1;
            r_de_prev <= 1'b0;
            r_x_cnt   <= '0;
            r_y_cnt   <= '0;
        end else begin
            r_vs_prev <= bus.vpg_vs;
            r_de_prev <= bus.vpg_de;
            r_x_cnt   <= bus.vpg_de ? r_x_cnt + CNT_W'(1) : '0;
            if (!bus.vpg_vs) begin
                r_y_cnt <= '0;
            end else if (w_de_fall) begin
                r_y_cnt <= r_y_cnt + CNT_W'(1);
            end
        end
    end

    // Box position and glyph base only change at frame start so a frame never tears.
    always_ff @(posedge vpg_pclk) begin
        if (reset) begin
            r_armed <= 1'b0;
            r_off_q <= '0;
            r_x_pos <= CNT_W'(X_INIT);
            r_y_pos <= CNT_W'(Y_INIT);
        end else if (w_fs) begin
            r_armed <= 1'b1;
            r_off_q <= bus.glyph_offset;
            if (bus.move_req) begin
                r_x_pos <= (w_x_next > SUM_W'(X_LIM)) ? '0 : CNT_W'(w_x_next);
                r_y_pos <= (w_y_next > SUM_W'(Y_LIM)) ? '0 : CNT_W'(w_y_next);
            end
        end
    end

    // Stage A: ROM request.
    always_ff @(posedge vpg_pclk) begin
        if (reset) begin
            r_rom_address <= '0;
            r_rom_rden    <= 1'b0;
        end else begin
            r_rom_address <= w_in_box ? w_addr : r_off_q;
            r_rom_rden    <= w_in_box;
        end
    end

    // Video delay line spanning the stage A register plus ROM latency.
    always_ff @(posedge vpg_pclk) begin
        if (reset) begin
            for (int i = 0; i < DLY_N; i++) begin
                r_dly[i] <= VID_RST;
            end
        end else begin
            r_dly[0] <= '{de: bus.vpg_de, hs: bus.vpg_hs, vs: bus.vpg_vs,
                          in_box: w_in_box, d: bus.vpg_d};
            for (int i = 1; i < DLY_N; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
        end
    end

    // Output stage: ROM bit lands on the same cycle as its pixel and overlay enable.
    always_ff @(posedge vpg_pclk) begin
        if (reset) begin
            r_out_de  <= 1'b0;
            r_out_hs  <= 1'b1;
            r_out_vs  <= 1'b1;
            r_out_d   <= '0;
            r_ovl_bit <= 1'b0;
            r_ovl_en  <= 1'b0;
        end else begin
            r_out_de  <= w_tail.de;
            r_out_hs  <= w_tail.hs;
            r_out_vs  <= w_tail.vs;
            r_out_d   <= w_tail.d;
            r_ovl_bit <= bus.rom_q & w_tail.in_box;
            r_ovl_en  <= w_tail.in_box;
        end
    end

    assign bus.rom_address = r_rom_address;
    assign bus.rom_rden    = r_rom_rden;
    assign bus.out_de      = r_out_de;
    assign bus.out_hs      = r_out_hs;
    assign bus.out_vs      = r_out_vs;
    assign bus.out_d       = r_out_d;
    assign bus.ovl_bit     = r_ovl_bit;
    assign bus.ovl_en      = r_ovl_en;
endmodule
